// File: rtl/keypad_signed_entry.sv
// keypad_signed_entry
//   Scans a 4x4 active-low matrix keypad and debounces key presses. It builds a
//   signed decimal entry of up to DIGITS digits. On the enter key it range-checks
//   the entry against a WIDTH-bit two's-complement range. An accepted entry is
//   presented on a valid/ready handshake.
//
// Ports
//   CLOCK      system clock
//   RESET      asynchronous, active-high reset
//   row[3:0]   keypad rows, active-low (pressed key pulls its row low while its column is low)
//   col[3:0]   column drive, one-hot active-low, rotating col[0]..col[3]
//   out_value  committed entry, WIDTH-bit two's complement; stable while out_valid
//   out_valid  out_value valid, held until out_ready
//   out_ready  downstream accepts out_value
//   err        one-clock pulse on a rejected commit (out of range, or enter with no digits)
//   entry_mag  live unsigned magnitude of the entry in progress
//   entry_neg  live sign of the entry in progress
//   in_range   live entry fits the WIDTH range (combinational)
//
// Key map (row r / col c):  r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
//   A = sign toggle, B = backspace, * = clear, # = enter, C/D ignored.
module keypad_signed_entry #(
  parameter int DIGITS   = 3,
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [13:0]      entry_mag,
  output logic             entry_neg,
  output logic             in_range
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int CNT_W = $clog2(DIGITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_FIRE   = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIGITS);
  localparam logic [16:0]      POS_LIMIT = 17'((1 << (WIDTH - 1)) - 1);
  localparam logic [16:0]      NEG_LIMIT = 17'(1 << (WIDTH - 1));

  // Key codes are {row, col}
  localparam logic [3:0] KEY_SIGN = 4'd3;
  localparam logic [3:0] KEY_BS   = 4'd7;
  localparam logic [3:0] KEY_CLR  = 4'd12;
  localparam logic [3:0] KEY_ZERO = 4'd13;
  localparam logic [3:0] KEY_ENT  = 4'd14;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;   // keys seen so far this frame: 0, 1, 2 = many
  logic [3:0]       acc_key_q, acc_key_d;
  logic [3:0]       db_key_q, db_key_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_lock_q, db_lock_d;   // event fired; wait for an all-released frame
  logic [13:0]      mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             err_q, err_d;

  logic             sample;
  logic             frame_done;
  logic [3:0]       row_hit;
  logic [2:0]       hit_cnt;
  logic [1:0]       hit_row;
  logic [2:0]       frame_sum;
  logic [1:0]       frame_cnt;
  logic [3:0]       frame_key;
  logic [DB_W-1:0]  run_len;
  logic             key_event;
  logic             live_event;
  logic [1:0]       key_r;
  logic [1:0]       key_c;
  logic             key_is_digit;
  logic [3:0]       key_digit;
  logic [16:0]      mag_ext;
  logic             fits;

  // ---------------- scan ----------------
  assign sample     = (div_q == DIV_LAST);
  assign frame_done = sample && (col_idx_q == 2'd3);
  assign row_hit    = ~row;

  // Count pressed rows in the driven column and remember the lowest one
  always_comb begin
    hit_cnt = 3'd0;
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_hit[i]) begin
        hit_cnt = hit_cnt + 3'd1;
        hit_row = 2'(i);
      end
    end
  end

  // Frame result including the column being sampled right now
  assign frame_sum = {1'b0, acc_cnt_q} + hit_cnt;
  assign frame_cnt = (frame_sum >= 3'd2) ? 2'd2 : frame_sum[1:0];
  assign frame_key = (hit_cnt != 3'd0) ? {hit_row, col_idx_q} : acc_key_q;

  // Scan counters, frame accumulation and debounce
  always_comb begin
    div_d     = div_q;
    col_idx_d = col_idx_q;
    acc_cnt_d = acc_cnt_q;
    acc_key_d = acc_key_q;
    db_key_d  = db_key_q;
    db_cnt_d  = db_cnt_q;
    db_lock_d = db_lock_q;
    run_len   = '0;
    key_event = 1'b0;

    if (sample) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (frame_done) begin
        acc_cnt_d = 2'd0;
        acc_key_d = 4'd0;
      end else begin
        acc_cnt_d = frame_cnt;
        acc_key_d = frame_key;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (frame_done) begin
      case (frame_cnt)
        2'd0: begin
          db_cnt_d  = '0;
          db_lock_d = 1'b0;
        end
        2'd1: begin
          if (!db_lock_q) begin
            run_len  = (db_cnt_q != '0 && frame_key == db_key_q) ? db_cnt_q + DB_W'(1) : DB_W'(1);
            db_key_d = frame_key;
            if (run_len == DB_FIRE) begin
              key_event = 1'b1;
              db_lock_d = 1'b1;
              db_cnt_d  = '0;
            end else begin
              db_cnt_d = run_len;
            end
          end
        end
        default: db_cnt_d = '0;   // several keys at once: start over
      endcase
    end
  end

  // ---------------- key decode / range ----------------
  assign key_r = frame_key[3:2];
  assign key_c = frame_key[1:0];

  always_comb begin
    key_is_digit = 1'b0;
    key_digit    = 4'd0;
    if (frame_key == KEY_ZERO) begin
      key_is_digit = 1'b1;
    end else if (key_r != 2'd3 && key_c != 2'd3) begin
      key_is_digit = 1'b1;
      key_digit    = {2'b00, key_r} * 4'd3 + {2'b00, key_c} + 4'd1;
    end
  end

  // Events arriving in HOLD (including the handshake clock) are dropped
  assign live_event = key_event && (state_q != S_HOLD);

  assign mag_ext = {3'b000, mag_q};
  assign fits    = neg_q ? (mag_ext <= NEG_LIMIT) : (mag_ext <= POS_LIMIT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (live_event && key_is_digit) state_d = S_ENTRY;
      S_ENTRY: begin
        if (live_event) begin
          if (frame_key == KEY_CLR)                          state_d = S_EMPTY;
          else if (frame_key == KEY_BS && cnt_q == CNT_W'(1)) state_d = S_EMPTY;
          else if (frame_key == KEY_ENT)                     state_d = fits ? S_HOLD : S_EMPTY;
        end
      end
      S_HOLD:  if (out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------- FSM: outputs / entry datapath ----------------
  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    val_d = val_q;
    err_d = 1'b0;
    if (live_event) begin
      if (key_is_digit) begin
        if (cnt_q != CNT_MAX) begin
          mag_d = 14'(({4'b0000, mag_q} * 18'd10) + {14'd0, key_digit});
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        case (frame_key)
          KEY_SIGN: neg_d = ~neg_q;
          KEY_BS: begin
            if (cnt_q != '0) begin
              mag_d = mag_q / 14'd10;
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          KEY_CLR: begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
          end
          KEY_ENT: begin
            if (state_q == S_EMPTY) begin
              err_d = 1'b1;
            end else begin
              if (fits) val_d = neg_q ? WIDTH'(17'd0 - mag_ext) : WIDTH'(mag_ext);
              else      err_d = 1'b1;
              mag_d = '0;
              neg_d = 1'b0;
              cnt_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      acc_cnt_q <= 2'd0;
      acc_key_q <= 4'd0;
      db_key_q  <= 4'd0;
      db_cnt_q  <= '0;
      db_lock_q <= 1'b0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      val_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      acc_cnt_q <= acc_cnt_d;
      acc_key_q <= acc_key_d;
      db_key_q  <= db_key_d;
      db_cnt_q  <= db_cnt_d;
      db_lock_q <= db_lock_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      err_q     <= err_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign out_value = val_q;
  assign out_valid = (state_q == S_HOLD);
  assign err       = err_q;
  assign entry_mag = mag_q;
  assign entry_neg = neg_q;
  assign in_range  = fits;

endmodule

// File: tb/tb_keypad_signed_entry.sv
// Testbench for keypad_signed_entry: a default instance (DIGITS=3, WIDTH=8) and
// a wide instance (DIGITS=4, WIDTH=12) share clock and reset. Each instance has
// its own modelled keypad matrix. A behavioural model tracks the entry by the
// key rules.
module tb_keypad_signed_entry;

  localparam int FRAME = 16;   // 4 columns * SCAN_DIV

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_a, col_a, row_b, col_b;
  logic [7:0]  val_a;
  logic [11:0] val_b;
  logic        valid_a, valid_b, ready_a, ready_b, err_a, err_b;
  logic        neg_a, neg_b, inr_a, inr_b;
  logic [13:0] mag_a, mag_b;
  logic [15:0] keys_a, keys_b;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen [2] = '{0, 0};

  // model state
  int m_mag [2];
  int m_neg [2];
  int m_cnt [2];
  int m_val [2];
  int m_err [2];
  int m_hold [2];
  int m_w [2] = '{8, 12};
  int m_d [2] = '{3, 4};
  string keymap = "123A456B789C*0#D";

  always #5 clk = ~clk;

  keypad_signed_entry u_dut (
    .CLOCK(clk), .RESET(rst), .row(row_a), .col(col_a),
    .out_value(val_a), .out_valid(valid_a), .out_ready(ready_a), .err(err_a),
    .entry_mag(mag_a), .entry_neg(neg_a), .in_range(inr_a)
  );

  keypad_signed_entry #(.DIGITS(4), .WIDTH(12)) u_wide (
    .CLOCK(clk), .RESET(rst), .row(row_b), .col(col_b),
    .out_value(val_b), .out_valid(valid_b), .out_ready(ready_b), .err(err_b),
    .entry_mag(mag_b), .entry_neg(neg_b), .in_range(inr_b)
  );

  // Keypad matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    row_a = 4'hF;
    row_b = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_a[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
        if (keys_b[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (err_a === 1'b1) err_seen[0] <= err_seen[0] + 1;
    if (err_b === 1'b1) err_seen[1] <= err_seen[1] + 1;
  end

  function automatic int pos_of(byte ch);
    for (int i = 0; i < 16; i++) if (keymap[i] == ch) return i;
    return 15;
  endfunction

  function automatic bit model_fits(int d);
    int lim;
    lim = m_neg[d] != 0 ? (1 << (m_w[d] - 1)) : (1 << (m_w[d] - 1)) - 1;
    return m_mag[d] <= lim;
  endfunction

  function automatic void model_clear(int d);
    m_mag[d] = 0;
    m_neg[d] = 0;
    m_cnt[d] = 0;
  endfunction

  function automatic void model_key(int d, byte ch);
    if (m_hold[d] != 0) return;
    if (ch >= 8'd48 && ch <= 8'd57) begin
      if (m_cnt[d] < m_d[d]) begin
        m_mag[d] = m_mag[d] * 10 + (ch - 8'd48);
        m_cnt[d]++;
      end
    end else if (ch == "A") begin
      m_neg[d] = 1 - m_neg[d];
    end else if (ch == "B") begin
      if (m_cnt[d] > 0) begin
        m_mag[d] = m_mag[d] / 10;
        m_cnt[d]--;
      end
    end else if (ch == "*") begin
      model_clear(d);
    end else if (ch == "#") begin
      if (m_cnt[d] == 0) begin
        m_err[d]++;
      end else begin
        if (model_fits(d)) begin
          m_val[d]  = m_neg[d] != 0 ? ((1 << m_w[d]) - m_mag[d]) & ((1 << m_w[d]) - 1) : m_mag[d];
          m_hold[d] = 1;
        end else begin
          m_err[d]++;
        end
        model_clear(d);
      end
    end
  endfunction

  task automatic press_mask(int d, logic [15:0] mask, int hold_frames, int rel_frames);
    repeat ($urandom_range(0, FRAME - 1)) @(posedge clk);
    #1;
    if (d == 0) keys_a = mask; else keys_b = mask;
    repeat (hold_frames * FRAME) @(posedge clk);
    #1;
    if (d == 0) keys_a = '0; else keys_b = '0;
    repeat (rel_frames * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic press(int d, byte ch);
    press_mask(d, 16'(1) << pos_of(ch), 4, 2);
    model_key(d, ch);
    $display("[%0t] dut%0d key %c mag_a=%0d mag_b=%0d valid_a=%0b valid_b=%0b",
             $time, d, ch, mag_a, mag_b, valid_a, valid_b);
  endtask

  task automatic handshake(int d);
    if (d == 0) ready_a = 1'b1; else ready_b = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    m_hold[d] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (col_a !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b exp 1110", col_a); end
    n_checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b exp 00", valid_a, valid_b); end
    n_checks++; if (val_a !== 8'h00 || val_b !== 12'h000) begin n_fail++; $display("FAIL reset_value: got %h %h exp 0", val_a, val_b); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err_a); end
    n_checks++; if (mag_a !== 14'd0 || neg_a !== 1'b0) begin n_fail++; $display("FAIL reset_entry: got %0d/%b exp 0/0", mag_a, neg_a); end
    n_checks++; if (inr_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_range: got %b exp 1", inr_a); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (col_a !== 4'b1110) begin n_fail++; $display("FAIL scan_hold_col: got %b exp 1110", col_a); end
    @(posedge clk);
    #1;
    n_checks++; if (col_b !== 4'b1101) begin n_fail++; $display("FAIL scan_advance_col: got %b exp 1101", col_b); end
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_seen[0];
    press(0, "1");
    n_checks++; if (mag_a !== 14'd1) begin n_fail++; $display("FAIL basic_first_digit: got %0d exp 1", mag_a); end
    press(0, "2");
    press(0, "7");
    n_checks++; if (mag_a !== 14'd127 || inr_a !== 1'b1) begin n_fail++; $display("FAIL basic_127: got %0d/%b exp 127/1", mag_a, inr_a); end
    press(0, "#");
    n_checks++; if (valid_a !== 1'b1 || val_a !== 8'h7F) begin n_fail++; $display("FAIL basic_commit: got %b/%h exp 1/7f", valid_a, val_a); end
    n_checks++; if (err_seen[0] !== e0 || mag_a !== 14'd0) begin n_fail++; $display("FAIL basic_err_clear: got %0d/%0d exp %0d/0", err_seen[0], mag_a, e0); end
    handshake(0);
    n_checks++; if (valid_a !== 1'b0 || val_a !== 8'h7F) begin n_fail++; $display("FAIL basic_accept: got %b/%h exp 0/7f", valid_a, val_a); end
  endtask

  task automatic test_negative();
    int e0;
    press(0, "A");
    n_checks++; if (neg_a !== 1'b1 || inr_a !== 1'b1) begin n_fail++; $display("FAIL neg_sign: got %b/%b exp 1/1", neg_a, inr_a); end
    press(0, "1");
    press(0, "2");
    press(0, "8");
    n_checks++; if (mag_a !== 14'd128 || inr_a !== 1'b1) begin n_fail++; $display("FAIL neg_128_range: got %0d/%b exp 128/1", mag_a, inr_a); end
    press(0, "#");
    n_checks++; if (valid_a !== 1'b1 || val_a !== 8'h80) begin n_fail++; $display("FAIL neg_commit: got %b/%h exp 1/80", valid_a, val_a); end
    handshake(0);
    e0 = err_seen[0];
    press(0, "1");
    press(0, "2");
    press(0, "8");
    n_checks++; if (inr_a !== 1'b0) begin n_fail++; $display("FAIL pos_128_range: got %b exp 0", inr_a); end
    press(0, "#");
    n_checks++; if (err_seen[0] !== e0 + 1) begin n_fail++; $display("FAIL pos_128_err: got %0d exp %0d", err_seen[0], e0 + 1); end
    n_checks++; if (valid_a !== 1'b0 || mag_a !== 14'd0 || val_a !== 8'h80) begin n_fail++; $display("FAIL pos_128_state: got %b/%0d/%h exp 0/0/80", valid_a, mag_a, val_a); end
  endtask

  task automatic test_backspace();
    press(0, "4");
    press(0, "5");
    press(0, "6");
    press(0, "7");
    n_checks++; if (mag_a !== 14'd456 || inr_a !== 1'b0) begin n_fail++; $display("FAIL digit_limit: got %0d/%b exp 456/0", mag_a, inr_a); end
    press(0, "B");
    n_checks++; if (mag_a !== 14'd45 || inr_a !== 1'b1) begin n_fail++; $display("FAIL backspace: got %0d/%b exp 45/1", mag_a, inr_a); end
    press(0, "*");
    n_checks++; if (mag_a !== 14'd0 || neg_a !== 1'b0) begin n_fail++; $display("FAIL clear: got %0d/%b exp 0/0", mag_a, neg_a); end
    press(0, "A");
    press(0, "3");
    press(0, "B");
    n_checks++; if (mag_a !== 14'd0 || neg_a !== 1'b1) begin n_fail++; $display("FAIL bs_to_empty_keeps_sign: got %0d/%b exp 0/1", mag_a, neg_a); end
    press(0, "*");
    n_checks++; if (neg_a !== 1'b0) begin n_fail++; $display("FAIL clear_sign: got %b exp 0", neg_a); end
  endtask

  task automatic test_debounce();
    int e0;
    press_mask(0, 16'(1) << pos_of("5"), 20, 2);
    model_key(0, "5");
    n_checks++; if (mag_a !== 14'd5) begin n_fail++; $display("FAIL long_hold_single: got %0d exp 5", mag_a); end
    press_mask(0, (16'(1) << pos_of("5")) | (16'(1) << pos_of("6")), 4, 2);
    n_checks++; if (mag_a !== 14'd5) begin n_fail++; $display("FAIL multi_key_ignored: got %0d exp 5", mag_a); end
    press(0, "*");
    e0 = err_seen[0];
    press(0, "#");
    n_checks++; if (err_seen[0] !== e0 + 1 || valid_a !== 1'b0 || mag_a !== 14'd0) begin n_fail++; $display("FAIL enter_empty: got %0d/%b/%0d exp %0d/0/0", err_seen[0], valid_a, mag_a, e0 + 1); end
  endtask

  task automatic test_hold();
    press(0, "4");
    press(0, "2");
    press(0, "#");
    n_checks++; if (valid_a !== 1'b1 || val_a !== 8'h2A) begin n_fail++; $display("FAIL hold_commit: got %b/%h exp 1/2a", valid_a, val_a); end
    press(0, "9");
    n_checks++; if (val_a !== 8'h2A || mag_a !== 14'd0 || valid_a !== 1'b1) begin n_fail++; $display("FAIL hold_discard: got %h/%0d/%b exp 2a/0/1", val_a, mag_a, valid_a); end
    ready_a = 1'b1;
    #1;
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL hold_before_edge: got %b exp 1", valid_a); end
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    m_hold[0] = 0;
    n_checks++; if (valid_a !== 1'b0 || val_a !== 8'h2A) begin n_fail++; $display("FAIL hold_release: got %b/%h exp 0/2a", valid_a, val_a); end
  endtask

  task automatic test_reset_hold();
    press(0, "1");
    press(0, "#");
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL rh_commit: got %b exp 1", valid_a); end
    repeat (7) @(posedge clk);
    #1;
    keys_a = 16'(1) << pos_of("3");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    n_checks++; if (valid_a !== 1'b0 || val_a !== 8'h00 || col_a !== 4'b1110) begin n_fail++; $display("FAIL rh_async: got %b/%h/%b exp 0/00/1110", valid_a, val_a, col_a); end
    n_checks++; if (mag_a !== 14'd0 || neg_a !== 1'b0 || err_a !== 1'b0) begin n_fail++; $display("FAIL rh_entry: got %0d/%b/%b exp 0/0/0", mag_a, neg_a, err_a); end
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_val[d]  = 0;
      m_hold[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * FRAME - 1) @(posedge clk);
    #1;
    n_checks++; if (mag_a !== 14'd0) begin n_fail++; $display("FAIL rh_too_early: got %0d exp 0", mag_a); end
    @(posedge clk);
    #1;
    n_checks++; if (mag_a !== 14'd3) begin n_fail++; $display("FAIL rh_fires: got %0d exp 3", mag_a); end
    keys_a = '0;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    model_key(0, "3");
  endtask

  task automatic test_wide();
    press(1, "A");
    press(1, "2");
    press(1, "0");
    press(1, "4");
    press(1, "8");
    n_checks++; if (mag_b !== 14'd2048 || neg_b !== 1'b1 || inr_b !== 1'b1) begin n_fail++; $display("FAIL wide_entry: got %0d/%b/%b exp 2048/1/1", mag_b, neg_b, inr_b); end
    press(1, "#");
    n_checks++; if (valid_b !== 1'b1 || val_b !== 12'h800) begin n_fail++; $display("FAIL wide_commit: got %b/%h exp 1/800", valid_b, val_b); end
    handshake(1);
    press(1, "2");
    press(1, "0");
    press(1, "4");
    press(1, "7");
    press(1, "#");
    n_checks++; if (valid_b !== 1'b1 || val_b !== 12'h7FF) begin n_fail++; $display("FAIL wide_pos_max: got %b/%h exp 1/7ff", valid_b, val_b); end
    handshake(1);
  endtask

  task automatic test_random();
    string extra = "AB*#C#";
    logic [31:0] o_mag, o_val;
    logic o_neg, o_inr, o_vld;
    for (int it = 0; it < 60; it++) begin
      int d;
      int k;
      byte ch;
      d = int'($urandom_range(0, 1));
      if (m_hold[d] != 0 && $urandom_range(0, 1) == 1) handshake(d);
      k = int'($urandom_range(0, 15));
      if (k < 10) ch = byte'(48 + k);
      else        ch = extra[k - 10];
      press(d, ch);
      if (d == 0) begin
        o_mag = 32'(mag_a); o_val = 32'(val_a); o_neg = neg_a; o_inr = inr_a; o_vld = valid_a;
      end else begin
        o_mag = 32'(mag_b); o_val = 32'(val_b); o_neg = neg_b; o_inr = inr_b; o_vld = valid_b;
      end
      n_checks++; if (o_mag !== 32'(m_mag[d])) begin n_fail++; $display("FAIL rnd_mag dut%0d: got %0d exp %0d", d, o_mag, m_mag[d]); end
      n_checks++; if (o_neg !== m_neg[d][0]) begin n_fail++; $display("FAIL rnd_neg dut%0d: got %b exp %0d", d, o_neg, m_neg[d]); end
      n_checks++; if (o_inr !== model_fits(d)) begin n_fail++; $display("FAIL rnd_in_range dut%0d: got %b exp %b", d, o_inr, model_fits(d)); end
      n_checks++; if (o_vld !== m_hold[d][0]) begin n_fail++; $display("FAIL rnd_valid dut%0d: got %b exp %0d", d, o_vld, m_hold[d]); end
      n_checks++; if (o_val !== 32'(m_val[d])) begin n_fail++; $display("FAIL rnd_value dut%0d: got %h exp %h", d, o_val, m_val[d]); end
      n_checks++; if (err_seen[d] !== m_err[d]) begin n_fail++; $display("FAIL rnd_err dut%0d: got %0d exp %0d", d, err_seen[d], m_err[d]); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    keys_a  = '0;
    keys_b  = '0;
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_val[d]  = 0;
      m_err[d]  = 0;
      m_hold[d] = 0;
    end
    test_reset();
    test_basic();
    test_negative();
    test_backspace();
    test_debounce();
    test_hold();
    test_reset_hold();
    test_wide();
    // err counters kept by the monitor are the reference from here on
    m_err[0] = err_seen[0];
    m_err[1] = err_seen[1];
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
